// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: per-stage enables/flushes from load-use, redirect,
// data-memory wait and debug halt/step, plus saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned WAIT_W      = 8,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter logic [1:0]  LOAD_SEL    = 2'b01
) (
    input  logic             clk_HzCtrl,
    input  logic             rst_HzCtrl,
    input  logic [4:0]       Rs1_addr_ID_HzCtrl,
    input  logic             Rs1_used_ID_HzCtrl,
    input  logic [4:0]       Rs2_addr_ID_HzCtrl,
    input  logic             Rs2_used_ID_HzCtrl,
    input  logic [4:0]       Rd_addr_IDEX_HzCtrl,
    input  logic [1:0]       MemtoReg_IDEX_HzCtrl,
    input  logic             RegWrite_IDEX_HzCtrl,
    input  logic             redirect_Mem_HzCtrl,
    input  logic             dmem_req_HzCtrl,
    input  logic             dmem_ready_HzCtrl,
    input  logic             halt_req_HzCtrl,
    input  logic             step_HzCtrl,
    output logic             en_PC_HzCtrl,
    output logic             en_IFID_HzCtrl,
    output logic             en_IDEX_HzCtrl,
    output logic             en_EXMem_HzCtrl,
    output logic             en_MemWB_HzCtrl,
    output logic             flush_IFID_HzCtrl,
    output logic             flush_IDEX_HzCtrl,
    output logic             flush_EXMem_HzCtrl,
    output logic             halted_HzCtrl,
    output logic             timeout_err_HzCtrl,
    output logic [CNT_W-1:0] stall_cnt_HzCtrl,
    output logic [CNT_W-1:0] flush_cnt_HzCtrl
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT, STEP} state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              load_use;
    logic              advance;
    logic              freeze;
    logic              bubble;
    logic              applied_redirect;
    logic              set_terr;

    assign load_use = (MemtoReg_IDEX_HzCtrl == LOAD_SEL) && RegWrite_IDEX_HzCtrl &&
                      (Rd_addr_IDEX_HzCtrl != 5'd0) &&
                      ((Rs1_used_ID_HzCtrl && (Rs1_addr_ID_HzCtrl == Rd_addr_IDEX_HzCtrl)) ||
                       (Rs2_used_ID_HzCtrl && (Rs2_addr_ID_HzCtrl == Rd_addr_IDEX_HzCtrl)));

    // Next-state: classify each cycle as advance, freeze or halted.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        advance   = 1'b0;
        freeze    = 1'b0;
        set_terr  = 1'b0;
        case (state)
            RUN, STEP: begin
                if (dmem_req_HzCtrl && !dmem_ready_HzCtrl) begin
                    freeze    = 1'b1;
                    wait_nxt  = WAIT_W'(1);
                    state_nxt = MEM_WAIT;
                end else begin
                    advance   = 1'b1;
                    state_nxt = halt_req_HzCtrl ? HALT : RUN;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready_HzCtrl || (wait_cnt == WAIT_W'(MEM_TIMEOUT))) begin
                    advance   = 1'b1;
                    set_terr  = !dmem_ready_HzCtrl;
                    wait_nxt  = '0;
                    state_nxt = halt_req_HzCtrl ? HALT : RUN;
                end else begin
                    freeze   = 1'b1;
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            HALT: begin
                if (!halt_req_HzCtrl) begin
                    state_nxt = RUN;
                end else if (step_HzCtrl) begin
                    state_nxt = STEP;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign applied_redirect = advance && redirect_Mem_HzCtrl;
    assign bubble           = advance && !redirect_Mem_HzCtrl && load_use;

    // Stage controls; forced inactive while reset is held.
    always_comb begin
        en_PC_HzCtrl       = 1'b0;
        en_IFID_HzCtrl     = 1'b0;
        en_IDEX_HzCtrl     = 1'b0;
        en_EXMem_HzCtrl    = 1'b0;
        en_MemWB_HzCtrl    = 1'b0;
        flush_IFID_HzCtrl  = 1'b0;
        flush_IDEX_HzCtrl  = 1'b0;
        flush_EXMem_HzCtrl = 1'b0;
        halted_HzCtrl      = rst_HzCtrl && (state == HALT);
        if (rst_HzCtrl && advance) begin
            en_IDEX_HzCtrl  = 1'b1;
            en_EXMem_HzCtrl = 1'b1;
            en_MemWB_HzCtrl = 1'b1;
            if (redirect_Mem_HzCtrl) begin
                en_PC_HzCtrl       = 1'b1;
                en_IFID_HzCtrl     = 1'b1;
                flush_IFID_HzCtrl  = 1'b1;
                flush_IDEX_HzCtrl  = 1'b1;
                flush_EXMem_HzCtrl = 1'b1;
            end else if (load_use) begin
                flush_IDEX_HzCtrl = 1'b1;
            end else begin
                en_PC_HzCtrl   = 1'b1;
                en_IFID_HzCtrl = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_HzCtrl or negedge rst_HzCtrl) begin
        if (!rst_HzCtrl) begin
            state              <= RUN;
            wait_cnt           <= '0;
            timeout_err_HzCtrl <= 1'b0;
            stall_cnt_HzCtrl   <= '0;
            flush_cnt_HzCtrl   <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (set_terr) begin
                timeout_err_HzCtrl <= 1'b1;
            end
            if ((freeze || bubble) && (stall_cnt_HzCtrl != '1)) begin
                stall_cnt_HzCtrl <= stall_cnt_HzCtrl + CNT_W'(1);
            end
            if (applied_redirect && (flush_cnt_HzCtrl != '1)) begin
                flush_cnt_HzCtrl <= flush_cnt_HzCtrl + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard/halt/timeout cases
// followed by randomized traffic against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CW  = 6;
    localparam int unsigned TO  = 4;
    localparam int          MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [4:0]    rs1, rs2, rd;
    logic          rs1u, rs2u, rw, redirect, req, ready, halt, step;
    logic [1:0]    m2r;
    logic          en_pc, en_ifid, en_idex, en_exmem, en_memwb;
    logic          fl_ifid, fl_idex, fl_exmem, halted, terr;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(.CNT_W(CW), .WAIT_W(8), .MEM_TIMEOUT(TO), .LOAD_SEL(2'b01)) dut (
        .clk_HzCtrl(clk), .rst_HzCtrl(rst),
        .Rs1_addr_ID_HzCtrl(rs1), .Rs1_used_ID_HzCtrl(rs1u),
        .Rs2_addr_ID_HzCtrl(rs2), .Rs2_used_ID_HzCtrl(rs2u),
        .Rd_addr_IDEX_HzCtrl(rd), .MemtoReg_IDEX_HzCtrl(m2r), .RegWrite_IDEX_HzCtrl(rw),
        .redirect_Mem_HzCtrl(redirect), .dmem_req_HzCtrl(req), .dmem_ready_HzCtrl(ready),
        .halt_req_HzCtrl(halt), .step_HzCtrl(step),
        .en_PC_HzCtrl(en_pc), .en_IFID_HzCtrl(en_ifid), .en_IDEX_HzCtrl(en_idex),
        .en_EXMem_HzCtrl(en_exmem), .en_MemWB_HzCtrl(en_memwb),
        .flush_IFID_HzCtrl(fl_ifid), .flush_IDEX_HzCtrl(fl_idex), .flush_EXMem_HzCtrl(fl_exmem),
        .halted_HzCtrl(halted), .timeout_err_HzCtrl(terr),
        .stall_cnt_HzCtrl(stall_cnt), .flush_cnt_HzCtrl(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] en;
        logic [2:0] fl;
        logic       halted;
        logic       terr;
        int         stall;
        int         fcnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: mode 0=running, 1=halted, 2=single step; frozen = cycles spent in current access
    int   mode, frozen, stall_m, fcnt_m;
    bit   terr_m;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("en", 32'({en_pc, en_ifid, en_idex, en_exmem, en_memwb}), 32'(mon_e.en));
            chk("flush", 32'({fl_ifid, fl_idex, fl_exmem}), 32'(mon_e.fl));
            chk("halted", 32'(halted), 32'(mon_e.halted));
            chk("timeout_err", 32'(terr), 32'(mon_e.terr));
            chk("stall_cnt", 32'(stall_cnt), mon_e.stall);
            chk("flush_cnt", 32'(flush_cnt), mon_e.fcnt);
        end
    end

    function automatic int sat_inc(input int v);
        return (v < MAXC) ? v + 1 : v;
    endfunction

    // Predict this cycle's outputs from current inputs, then advance the model past the next edge.
    task automatic tick();
        exp_t e;
        bit   lu, adv, frz;
        e = '{en: 5'b0, fl: 3'b0, halted: 1'b0, terr: 1'b0, stall: 0, fcnt: 0};
        if (!rst) begin
            mode = 0; frozen = 0; stall_m = 0; fcnt_m = 0; terr_m = 0;
        end else begin
            e.stall = stall_m;
            e.fcnt  = fcnt_m;
            e.terr  = terr_m;
            lu = (m2r == 2'b01) && rw && (rd != 0) &&
                 ((rs1u && rs1 == rd) || (rs2u && rs2 == rd));
            adv = 0;
            frz = 0;
            if (mode == 1) begin
                e.halted = 1'b1;
                if (!halt) mode = 0;
                else if (step) mode = 2;
            end else if (frozen == 0 && req && !ready) begin
                frz = 1; frozen = 1;
            end else if (frozen > 0 && !ready && frozen < TO) begin
                frz = 1; frozen++;
            end else begin
                adv = 1;
                if (frozen > 0 && !ready) terr_m = 1;
                frozen = 0;
                mode = halt ? 1 : 0;
            end
            if (adv && redirect) begin
                e.en = 5'b11111; e.fl = 3'b111; fcnt_m = sat_inc(fcnt_m);
            end else if (adv && lu) begin
                e.en = 5'b00111; e.fl = 3'b010; stall_m = sat_inc(stall_m);
            end else if (adv) begin
                e.en = 5'b11111;
            end else if (frz) begin
                stall_m = sat_inc(stall_m);
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        rs1 = 0; rs2 = 0; rd = 0; rs1u = 0; rs2u = 0; rw = 0; m2r = 0;
        redirect = 0; req = 0; ready = 0; halt = 0; step = 0;
    endtask

    initial begin
        clr_in();
        mode = 0; frozen = 0; stall_m = 0; fcnt_m = 0; terr_m = 0;
        @(posedge clk);
        #1;
        tick(); tick();
        rst = 1'b1;
        tick();

        // load-use and its non-hazard variants
        rd = 5; m2r = 2'b01; rw = 1; rs1 = 5; rs1u = 1;
        tick();
        rd = 0; tick();
        rd = 5; rs1u = 0; tick();
        rs1u = 1; m2r = 2'b00; tick();
        m2r = 2'b01; rs1u = 0; rs2 = 5; rs2u = 1; tick();
        rw = 0; tick();
        rw = 1; redirect = 1; tick();
        clr_in(); tick();

        // memory wait of three cycles, then ready
        req = 1; tick(); tick(); tick();
        ready = 1; tick();
        clr_in(); tick();

        // timeout with redirect held
        req = 1; redirect = 1;
        repeat (5) tick();
        clr_in(); tick(); tick();

        // halt, step, release
        halt = 1; tick(); tick(); tick();
        step = 1; tick();
        step = 0; tick(); tick();
        halt = 0; tick(); tick();

        // reset during a memory wait
        req = 1; tick(); tick();
        rst = 1'b0; tick();
        rst = 1'b1; clr_in(); tick(); tick();

        for (int i = 0; i < 3000; i++) begin
            rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
            rd = 5'($urandom_range(0, 3));
            rs1u = 1'($urandom_range(0, 1)); rs2u = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1)); m2r = 2'($urandom_range(0, 3));
            redirect = ($urandom_range(0, 3) == 0);
            req = 1'($urandom_range(0, 1));
            ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) halt = ~halt;
            step = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 499) != 0);
            tick();
        end

        rst = 1'b1;
        clr_in();
        tick();
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain actual=%0d expected=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
